// File: rtl/mem_bridge.sv
// Memory bridge between the CPU control FSM and a single-word request/ack bus.
// Handles fetch/load/store arbitration, lane alignment, load extension and bus timeout.
module mem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        MEM_RST,
    input  logic        MEM_RDEN1,
    input  logic [31:0] MEM_ADDR1,
    input  logic        MEM_RDEN2,
    input  logic        MEM_WE2,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    output logic [31:0] MEM_DOUT1,
    output logic [31:0] MEM_DOUT2,
    output logic        MEM_BUSY,
    output logic        MEM_ERR,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    output logic [3:0]  BUS_BE,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    typedef enum logic [1:0] {T_FETCH, T_LOAD, T_STORE} tgt_t;

    localparam logic [7:0] TO8 = 8'(TIMEOUT);

    state_t      state_q, state_d;
    tgt_t        tgt_q, tgt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] dout1_q, dout1_d, dout2_q, dout2_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d, req_q, req_d, err_q, err_d;
    logic [1:0]  lo_q, lo_d, size_q, size_d;
    logic        sign_q, sign_d;

    logic        any_en, req_data, misalign;
    logic [31:0] req_addr, st_wdata, ld_sh, ld_val;
    logic [1:0]  req_size;
    logic [3:0]  st_be;

    always_comb begin
        any_en   = MEM_WE2 | MEM_RDEN2 | MEM_RDEN1;
        req_data = MEM_WE2 | MEM_RDEN2;
        req_addr = req_data ? MEM_ADDR2 : MEM_ADDR1;
        req_size = req_data ? MEM_SIZE : 2'b10;
        misalign = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

        case (req_size)
            2'b00:   begin st_wdata = {4{MEM_DIN2[7:0]}};  st_be = 4'b0001 << req_addr[1:0]; end
            2'b01:   begin st_wdata = {2{MEM_DIN2[15:0]}}; st_be = req_addr[1] ? 4'b1100 : 4'b0011; end
            default: begin st_wdata = MEM_DIN2;            st_be = 4'b1111; end
        endcase

        // Legal halves always have lo[0]=0, so one shift by lo*8 serves every size.
        ld_sh = BUS_RDATA >> {lo_q, 3'b000};
        case (size_q)
            2'b00:   ld_val = sign_q ? {{24{ld_sh[7]}}, ld_sh[7:0]}   : {24'b0, ld_sh[7:0]};
            2'b01:   ld_val = sign_q ? {{16{ld_sh[15]}}, ld_sh[15:0]} : {16'b0, ld_sh[15:0]};
            default: ld_val = ld_sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        req_d   = req_q;
        err_d   = 1'b0;
        lo_d    = lo_q;
        size_d  = size_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (any_en) begin
                    if (misalign) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = BUS;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        tgt_d   = MEM_WE2 ? T_STORE : (MEM_RDEN2 ? T_LOAD : T_FETCH);
                        we_d    = MEM_WE2;
                        addr_d  = {req_addr[31:2], 2'b00};
                        wdata_d = MEM_WE2 ? st_wdata : '0;
                        be_d    = MEM_WE2 ? st_be : '1;
                        lo_d    = req_addr[1:0];
                        size_d  = req_size;
                        sign_d  = MEM_SIGN;
                    end
                end
            end
            BUS: begin
                if (BUS_ACK) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (tgt_q == T_FETCH) dout1_d = BUS_RDATA;
                    else if (tgt_q == T_LOAD) dout2_d = ld_val;
                end else if (cnt_q + 8'd1 == TO8) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge MEM_RST) begin
        if (MEM_RST) begin
            state_q <= IDLE;
            tgt_q   <= T_FETCH;
            cnt_q   <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            req_q   <= req_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        MEM_BUSY = ~MEM_RST & (((state_q == IDLE) & any_en & ~misalign) | (state_q == BUS));
    end

    assign MEM_DOUT1 = dout1_q;
    assign MEM_DOUT2 = dout2_q;
    assign MEM_ERR   = err_q;
    assign BUS_REQ   = req_q;
    assign BUS_WE    = we_q;
    assign BUS_ADDR  = addr_q;
    assign BUS_WDATA = wdata_q;
    assign BUS_BE    = be_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with TIMEOUT=4: fetch, loads, stores, misalign,
// timeout, ack-at-limit and mid-transfer reset, all against hand-computed values.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rden1 = 1'b0, rden2 = 1'b0, we2 = 1'b0, sign = 1'b0;
    logic [31:0] addr1 = '0, addr2 = '0, din2 = '0;
    logic [1:0]  size = '0;
    logic [31:0] dout1, dout2, bus_addr, bus_wdata;
    logic        busy, err, bus_req, bus_we;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    int          cyc;

    mem_bridge #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .MEM_RST   (rst),
        .MEM_RDEN1 (rden1),
        .MEM_ADDR1 (addr1),
        .MEM_RDEN2 (rden2),
        .MEM_WE2   (we2),
        .MEM_ADDR2 (addr2),
        .MEM_DIN2  (din2),
        .MEM_SIZE  (size),
        .MEM_SIGN  (sign),
        .MEM_DOUT1 (dout1),
        .MEM_DOUT2 (dout2),
        .MEM_BUSY  (busy),
        .MEM_ERR   (err),
        .BUS_REQ   (bus_req),
        .BUS_WE    (bus_we),
        .BUS_ADDR  (bus_addr),
        .BUS_WDATA (bus_wdata),
        .BUS_BE    (bus_be),
        .BUS_ACK   (bus_ack),
        .BUS_RDATA (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drop_en();
        rden1 = 1'b0; rden2 = 1'b0; we2 = 1'b0;
    endtask

    task automatic start(input logic r1, input logic r2, input logic w2, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] d, input logic [1:0] sz,
                         input logic sg);
        @(negedge clk);
        rden1 = r1; rden2 = r2; we2 = w2;
        addr1 = a1; addr2 = a2; din2 = d; size = sz; sign = sg;
    endtask

    // Ack is raised during the ack_at-th BUS_REQ cycle (0 = never); returns after BUS_REQ falls.
    task automatic run_bus(input int ack_at, input logic [31:0] rd);
        bit done;
        done = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                @(negedge clk);
                if (bus_req) begin
                    cyc++;
                    if (cyc == 1) begin
                        s_addr = bus_addr; s_wdata = bus_wdata; s_be = bus_be; s_we = bus_we;
                        drop_en();
                    end
                    bus_ack   = (cyc == ack_at);
                    bus_rdata = rd;
                end else begin
                    bus_ack = 1'b0;
                    if (cyc > 0) done = 1'b1;
                end
            end
        end
        if (!done) check("bus_bound", 32'd0, 32'd1);
        drop_en();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_dout1", dout1, 32'h0);
        check("rst_dout2", dout2, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_req", {31'b0, bus_req}, 32'h0);
        check("rst_we", {31'b0, bus_we}, 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_be", {28'b0, bus_be}, 32'h0);
        rst = 1'b0;

        // Fetch, ack on the 4th BUS cycle (also the timeout-limit cycle: ack wins)
        start(1, 0, 0, 32'h10, 32'h0, 32'h0, 2'b10, 0);
        #1 check("fetch_busy_req", {31'b0, busy}, 32'h1);
        run_bus(4, 32'h00C58533);
        check("fetch_req_cycles", cyc, 32'd4);
        check("fetch_bus_addr", s_addr, 32'h10);
        check("fetch_be", {28'b0, s_be}, 32'hF);
        check("fetch_dout1", dout1, 32'h00C58533);
        check("fetch_busy_done", {31'b0, busy}, 32'h0);
        check("fetch_no_err", {31'b0, err}, 32'h0);
        check("fetch_dout2_kept", dout2, 32'h0);

        start(0, 1, 0, 32'h0, 32'h103, 32'h0, 2'b00, 1);
        run_bus(1, 32'h80FF_0000);
        check("lb_addr", s_addr, 32'h100);
        check("lb_we", {31'b0, s_we}, 32'h0);
        check("lb_dout2", dout2, 32'hFFFFFF80);
        check("lb_dout1_kept", dout1, 32'h00C58533);

        start(0, 1, 0, 32'h0, 32'h103, 32'h0, 2'b00, 0);
        run_bus(1, 32'h80FF_0000);
        check("lbu_dout2", dout2, 32'h00000080);

        start(0, 1, 0, 32'h0, 32'h102, 32'h0, 2'b01, 1);
        run_bus(2, 32'h80FF_0000);
        check("lh_dout2", dout2, 32'hFFFF80FF);

        start(0, 0, 1, 32'h0, 32'h202, 32'h1234ABCD, 2'b01, 0);
        run_bus(1, 32'hDEADBEEF);
        check("sh_addr", s_addr, 32'h200);
        check("sh_wdata", s_wdata, 32'hABCDABCD);
        check("sh_be", {28'b0, s_be}, 32'hC);
        check("sh_we", {31'b0, s_we}, 32'h1);
        check("sh_dout2_kept", dout2, 32'hFFFF80FF);

        // Store beats the simultaneous fetch
        start(1, 0, 1, 32'h40, 32'h201, 32'h00000055, 2'b00, 0);
        run_bus(1, 32'hDEADBEEF);
        check("sb_prio_we", {31'b0, s_we}, 32'h1);
        check("sb_wdata", s_wdata, 32'h55555555);
        check("sb_be", {28'b0, s_be}, 32'h2);
        check("sb_dout1_kept", dout1, 32'h00C58533);

        start(0, 1, 0, 32'h0, 32'h301, 32'h0, 2'b10, 0);
        #1 check("mis_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        drop_en();
        check("mis_err", {31'b0, err}, 32'h1);
        check("mis_req", {31'b0, bus_req}, 32'h0);
        @(negedge clk);
        check("mis_err_pulse", {31'b0, err}, 32'h0);
        check("mis_req_idle", {31'b0, bus_req}, 32'h0);
        check("mis_dout2_kept", dout2, 32'hFFFF80FF);

        start(0, 1, 0, 32'h0, 32'h100, 32'h0, 2'b11, 0);
        @(negedge clk);
        drop_en();
        check("ill_size_err", {31'b0, err}, 32'h1);

        start(1, 0, 0, 32'h44, 32'h0, 32'h0, 2'b10, 0);
        run_bus(0, 32'h11111111);
        check("to_req_cycles", cyc, 32'd4);
        check("to_err", {31'b0, err}, 32'h1);
        check("to_busy", {31'b0, busy}, 32'h0);
        check("to_dout1_kept", dout1, 32'h00C58533);
        @(negedge clk);
        check("to_err_pulse", {31'b0, err}, 32'h0);

        start(0, 1, 0, 32'h0, 32'h100, 32'h0, 2'b10, 0);
        @(negedge clk);
        drop_en();
        check("rb_req_before", {31'b0, bus_req}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rb_req", {31'b0, bus_req}, 32'h0);
        check("rb_busy", {31'b0, busy}, 32'h0);
        check("rb_dout1", dout1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_ack = 1'b0;
        check("rb_late_ack_dout2", dout2, 32'h0);
        check("rb_late_ack_dout1", dout1, 32'h0);
        check("rb_late_ack_req", {31'b0, bus_req}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
